// File: rtl/n1_sbus_ram.sv
`default_nettype none
// ============================================================================
// n1_sbus_ram : Wishbone stack-bus RAM target, one outstanding access
// Revision    : 1.0
// ============================================================================
module n1_sbus_ram #(
    parameter int SP_WIDTH    = 12,
    parameter int WAIT_STATES = 0,
    parameter int RS_BASE     = 2048
) (
    input  logic                clk_i,
    input  logic                async_rst_i,
    input  logic                sbus_cyc_i,
    input  logic                sbus_stb_i,
    input  logic                sbus_we_i,
    input  logic [SP_WIDTH-1:0] sbus_adr_i,
    input  logic [15:0]         sbus_dat_i,
    input  logic                sbus_tga_ps_i,
    input  logic                sbus_tga_rs_i,
    input  logic                sbus_lock_i,
    output logic                sbus_ack_o,
    output logic                sbus_err_o,
    output logic                sbus_rty_o,
    output logic                sbus_stall_o,
    output logic [15:0]         sbus_dat_o,
    output logic [1:0]          prb_state_o
);

    localparam logic [1:0]          c_idle      = 2'd0;
    localparam logic [1:0]          c_wait      = 2'd1;
    localparam logic [1:0]          c_resp      = 2'd2;
    localparam int                  c_depth     = 2 ** SP_WIDTH;
    localparam logic                c_zero_wait = (WAIT_STATES == 0);
    localparam logic [2:0]          c_wait_load = (WAIT_STATES == 0) ? 3'd0 : 3'(WAIT_STATES - 1);
    localparam logic [SP_WIDTH:0]   c_rs_base   = (SP_WIDTH + 1)'(RS_BASE);

    logic [1:0]          r_state;
    logic [1:0]          w_next_state;
    logic [2:0]          r_cnt;
    logic [SP_WIDTH-1:0] r_adr;
    logic                r_we;
    logic                r_ps;
    logic                r_rs;
    logic [15:0]         r_dat;
    logic                r_ack;
    logic                r_err;
    logic                r_rty;
    logic [15:0]         r_rdata;
    logic [15:0]         r_mem [c_depth];

    logic                w_stall;
    logic                w_accept;
    logic                w_enter_resp;
    logic                w_resp_err;
    logic                w_resp_rty;
    logic                w_resp_ack;
    logic                w_mem_wr;
    logic [SP_WIDTH-1:0] w_adr;
    logic                w_we;
    logic                w_ps;
    logic                w_rs;
    logic [15:0]         w_dat;

    assign w_stall  = (r_state == c_wait);
    assign w_accept = sbus_cyc_i & sbus_stb_i & ~w_stall;

    // Zero-wait accesses resolve on the accept edge itself, so they use the live bus.
    assign w_adr = w_stall ? r_adr : sbus_adr_i;
    assign w_we  = w_stall ? r_we  : sbus_we_i;
    assign w_ps  = w_stall ? r_ps  : sbus_tga_ps_i;
    assign w_rs  = w_stall ? r_rs  : sbus_tga_rs_i;
    assign w_dat = w_stall ? r_dat : sbus_dat_i;

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = c_idle;
        case (r_state)
            c_idle, c_resp: begin
                if (w_accept) begin
                    w_next_state = c_zero_wait ? c_resp : c_wait;
                end
            end
            c_wait: begin
                if (!sbus_cyc_i) begin
                    w_next_state = c_idle;
                end else if (r_cnt == 3'd0) begin
                    w_next_state = c_resp;
                end else begin
                    w_next_state = c_wait;
                end
            end
            default: w_next_state = c_idle;
        endcase
    end

    always_comb begin
        w_enter_resp = (w_next_state == c_resp);
        w_resp_err   = (w_ps == w_rs)
                     | (w_ps & ({1'b0, w_adr} >= c_rs_base))
                     | (w_rs & ({1'b0, w_adr} <  c_rs_base));
        w_resp_rty   = ~w_resp_err & sbus_lock_i;
        w_resp_ack   = ~w_resp_err & ~sbus_lock_i;
        w_mem_wr     = w_enter_resp & w_resp_ack & w_we & async_rst_i;
    end

    always_ff @(posedge clk_i or negedge async_rst_i) begin
        if (!async_rst_i) begin
            r_ack   <= 1'b0;
            r_err   <= 1'b0;
            r_rty   <= 1'b0;
            r_rdata <= 16'h0000;
            r_cnt   <= 3'd0;
            r_adr   <= '0;
            r_we    <= 1'b0;
            r_ps    <= 1'b0;
            r_rs    <= 1'b0;
            r_dat   <= 16'h0000;
        end else begin
            r_ack <= w_enter_resp & w_resp_ack;
            r_err <= w_enter_resp & w_resp_err;
            r_rty <= w_enter_resp & w_resp_rty;
            if (w_enter_resp && w_resp_ack && !w_we) begin
                r_rdata <= r_mem[w_adr];
            end
            if (w_accept) begin
                r_cnt <= c_wait_load;
                r_adr <= sbus_adr_i;
                r_we  <= sbus_we_i;
                r_ps  <= sbus_tga_ps_i;
                r_rs  <= sbus_tga_rs_i;
                r_dat <= sbus_dat_i;
            end else if (w_stall && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (w_mem_wr) begin
            r_mem[w_adr] <= w_dat;
        end
    end

    assign sbus_ack_o   = r_ack;
    assign sbus_err_o   = r_err;
    assign sbus_rty_o   = r_rty;
    assign sbus_stall_o = w_stall;
    assign sbus_dat_o   = r_rdata;
    assign prb_state_o  = r_state;

endmodule
`default_nettype wire

// File: tb/tb_n1_sbus_ram.sv
`default_nettype none
// ============================================================================
// tb_n1_sbus_ram : self-checking bench, three instances (WAIT_STATES 0/3/2)
// Revision       : 1.0
// ============================================================================
module tb_n1_sbus_ram;

    localparam int         SPW    = 12;
    localparam logic       H      = 1'b1;
    localparam logic       L      = 1'b0;
    localparam logic [1:0] R_NONE = 2'd0;
    localparam logic [1:0] R_ACK  = 2'd1;
    localparam logic [1:0] R_ERR  = 2'd2;
    localparam logic [1:0] R_RTY  = 2'd3;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           cyc, stb, we, ps, rs, lock;
    logic [SPW-1:0] adr;
    logic [15:0]    wdat;
    logic [2:0]     ack_v, err_v, rty_v, stall_v;
    logic [1:0]     prb_v [3];
    logic [15:0]    dat_v [3];
    int             n_vec = 0;
    int             n_bad = 0;

    logic [15:0]    mdl_mem [4096];
    logic [15:0]    mdl_dat;

    typedef struct {
        logic           cyc, stb, we;
        logic [SPW-1:0] adr;
        logic [15:0]    dat;
        logic           ps, rs, lock;
        logic [1:0]     resp;
        logic [15:0]    edat;
    } vec_t;
    vec_t tbl [16];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        n1_sbus_ram #(
            .SP_WIDTH(SPW),
            .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 3 : 2)),
            .RS_BASE(2048)
        ) u_dut (
            .clk_i(clk), .async_rst_i(rst_n),
            .sbus_cyc_i(cyc), .sbus_stb_i(stb), .sbus_we_i(we),
            .sbus_adr_i(adr), .sbus_dat_i(wdat),
            .sbus_tga_ps_i(ps), .sbus_tga_rs_i(rs), .sbus_lock_i(lock),
            .sbus_ack_o(ack_v[g]), .sbus_err_o(err_v[g]), .sbus_rty_o(rty_v[g]),
            .sbus_stall_o(stall_v[g]), .sbus_dat_o(dat_v[g]), .prb_state_o(prb_v[g])
        );
    end

    task automatic chk(input string nm, input int d, input logic [1:0] resp,
                       input logic stl, input logic [1:0] prb, input logic [15:0] dat);
        logic [23:0] got, exp;
        got = {ack_v[d], err_v[d], rty_v[d], stall_v[d], prb_v[d], 2'b00, dat_v[d]};
        exp = {resp == R_ACK, resp == R_ERR, resp == R_RTY, stl, prb, 2'b00, dat};
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s dut%0d: ack/err/rty/stall/prb/dat got %h required %h", nm, d, got, exp);
        end
    endtask

    task automatic drive(input logic c, input logic s, input logic w, input logic [SPW-1:0] a,
                         input logic [15:0] dd, input logic p, input logic r, input logic l);
        cyc = c; stb = s; we = w; adr = a; wdat = dd; ps = p; rs = r; lock = l;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Zero-wait reference: each accepted request is answered on the following cycle.
    task automatic model_step(input logic c, input logic s, input logic w, input logic [SPW-1:0] a,
                              input logic [15:0] d, input logic p, input logic r, input logic l,
                              output logic [1:0] resp);
        resp = R_NONE;
        if (c && s) begin
            if (p == r || (p && a >= 12'd2048) || (r && a < 12'd2048)) resp = R_ERR;
            else if (l) resp = R_RTY;
            else begin
                resp = R_ACK;
                if (w) mdl_mem[a] = d;
                else   mdl_dat = mdl_mem[a];
            end
        end
    endtask

    task automatic do_reset();
        drive(L, L, L, '0, 16'h0000, L, L, L);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) chk("reset", d, R_NONE, L, 2'd0, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic seq_access(input string nm, input int d, input int ws, input logic w,
                              input logic [SPW-1:0] a, input logic [15:0] dd, input logic p,
                              input logic r, input logic l, input logic [1:0] resp,
                              input logic [15:0] hold, input logic [15:0] edat);
        drive(H, H, w, a, dd, p, r, l);
        tick();
        drive(H, L, w, a, dd, p, r, l);
        for (int i = 0; i < ws; i++) begin
            chk({nm, "_wait"}, d, R_NONE, H, 2'd1, hold);
            tick();
        end
        chk({nm, "_resp"}, d, resp, L, 2'd2, edat);
        drive(L, L, L, a, dd, L, L, L);
        tick();
        chk({nm, "_idle"}, d, R_NONE, L, 2'd0, edat);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r_mdl;
        tbl[0]  = '{H, H, H, 12'd5,    16'hBEEF, H, L, L, R_ACK,  16'h0000};
        tbl[1]  = '{H, H, L, 12'd5,    16'h0000, H, L, L, R_ACK,  16'hBEEF};
        tbl[2]  = '{H, H, H, 12'd2048, 16'hAAAA, L, H, L, R_ACK,  16'hBEEF};
        tbl[3]  = '{H, H, H, 12'd2048, 16'h2222, H, L, L, R_ERR,  16'hBEEF};
        tbl[4]  = '{H, H, L, 12'd2048, 16'h0000, L, H, L, R_ACK,  16'hAAAA};
        tbl[5]  = '{H, H, H, 12'd5,    16'h3333, H, H, L, R_ERR,  16'hAAAA};
        tbl[6]  = '{H, H, L, 12'd5,    16'h0000, H, H, L, R_ERR,  16'hAAAA};
        tbl[7]  = '{H, H, H, 12'd5,    16'h4444, L, L, L, R_ERR,  16'hAAAA};
        tbl[8]  = '{H, H, L, 12'd5,    16'h0000, H, L, L, R_ACK,  16'hBEEF};
        tbl[9]  = '{H, H, H, 12'd10,   16'h1234, H, L, H, R_RTY,  16'hBEEF};
        tbl[10] = '{H, H, H, 12'd10,   16'h1234, H, L, L, R_ACK,  16'hBEEF};
        tbl[11] = '{H, H, L, 12'd10,   16'h0000, L, H, L, R_ERR,  16'hBEEF};
        tbl[12] = '{L, H, L, 12'd10,   16'h0000, H, L, L, R_NONE, 16'hBEEF};
        tbl[13] = '{H, L, L, 12'd10,   16'h0000, H, L, L, R_NONE, 16'hBEEF};
        tbl[14] = '{H, H, L, 12'd10,   16'h0000, H, L, H, R_RTY,  16'hBEEF};
        tbl[15] = '{H, H, L, 12'd10,   16'h0000, H, L, L, R_ACK,  16'h1234};

        mdl_dat = 16'h0000;
        do_reset();

        for (int i = 0; i < 16; i++) begin
            drive(tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].adr, tbl[i].dat,
                  tbl[i].ps, tbl[i].rs, tbl[i].lock);
            tick();
            model_step(tbl[i].cyc, tbl[i].stb, tbl[i].we, tbl[i].adr, tbl[i].dat,
                       tbl[i].ps, tbl[i].rs, tbl[i].lock, r_mdl);
            chk($sformatf("vec%0d", i), 0, tbl[i].resp, L,
                (tbl[i].resp == R_NONE) ? 2'd0 : 2'd2, tbl[i].edat);
        end

        // Random traffic over a pool of 8 parameter-stack and 8 return-stack words.
        for (int k = 0; k < 216; k++) begin
            logic [SPW-1:0] a;
            logic [15:0]    d;
            logic           c, s, w, p, r, l;
            int             t;
            a = (k % 16 < 8) ? 12'(100 + k % 16) : 12'(3000 + k % 16);
            d = 16'($urandom);
            if (k < 16) begin
                c = H; s = H; w = H; l = L; t = 0;
            end else begin
                c = ($urandom_range(7) != 0);
                s = ($urandom_range(3) != 0);
                w = $urandom_range(1) == 1;
                l = ($urandom_range(4) == 0);
                t = $urandom_range(9);
                a = ($urandom_range(1) == 1) ? 12'(100 + $urandom_range(7))
                                             : 12'(3008 + $urandom_range(7));
            end
            p = (a < 12'd2048);
            r = ~p;
            if (t == 7)      begin p = H; r = H; end
            else if (t == 8) begin p = L; r = L; end
            else if (t == 9) begin p = ~p; r = ~r; end
            drive(c, s, w, a, d, p, r, l);
            tick();
            model_step(c, s, w, a, d, p, r, l, r_mdl);
            chk(k < 16 ? "preload" : "random", 0, r_mdl, L,
                (r_mdl == R_NONE) ? 2'd0 : 2'd2, mdl_dat);
        end

        // Wait-state instance: write then read with three stall cycles each.
        do_reset();
        seq_access("ws3_wr", 1, 3, H, 12'd2100, 16'h5A5A, L, H, L, R_ACK, 16'h0000, 16'h0000);
        seq_access("ws3_rd", 1, 3, L, 12'd2100, 16'h0000, L, H, L, R_ACK, 16'h0000, 16'h5A5A);

        // Asynchronous reset in the middle of a waited access.
        drive(H, H, L, 12'd2100, 16'h0000, L, H, L);
        tick();
        chk("rst_in_wait", 1, R_NONE, H, 2'd1, 16'h5A5A);
        drive(H, L, L, 12'd2100, 16'h0000, L, H, L);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async", 1, R_NONE, L, 2'd0, 16'h0000);
        drive(L, L, L, '0, 16'h0000, L, L, L);
        @(negedge clk);
        rst_n = 1'b1;
        seq_access("post_rst", 1, 3, L, 12'd2100, 16'h0000, L, H, L, R_ACK, 16'h0000, 16'h5A5A);

        // Two-wait instance: cycle abort must leave memory and outputs untouched.
        do_reset();
        seq_access("ws2_wr", 2, 2, H, 12'd7, 16'h7777, H, L, L, R_ACK, 16'h0000, 16'h0000);
        drive(H, H, H, 12'd7, 16'h8888, H, L, L);
        tick();
        chk("abort_wait", 2, R_NONE, H, 2'd1, 16'h0000);
        drive(L, L, H, 12'd7, 16'h8888, H, L, L);
        tick();
        chk("abort_idle", 2, R_NONE, L, 2'd0, 16'h0000);
        tick();
        chk("abort_quiet", 2, R_NONE, L, 2'd0, 16'h0000);
        seq_access("ws2_rd",  2, 2, L, 12'd7, 16'h0000, H, L, L, R_ACK, 16'h0000, 16'h7777);
        seq_access("ws2_rty", 2, 2, H, 12'd7, 16'h9999, H, L, H, R_RTY, 16'h7777, 16'h7777);
        seq_access("ws2_err", 2, 2, L, 12'd7, 16'h0000, L, H, L, R_ERR, 16'h7777, 16'h7777);
        seq_access("ws2_rd2", 2, 2, L, 12'd7, 16'h0000, H, L, L, R_ACK, 16'h7777, 16'h7777);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
